mem_stage: RTL and testbench

Memory-access stage of the RV32 pipeline. It takes instructions from the EX/MEM pipeline and performs loads and stores on the data bus. It formats load data and detects misaligned accesses. It owns the MEM/WB pipeline register, so it is the producer side of the `wb_pipe_*` interface that the WB stage consumes.

---
 rtl/core_pkg.sv | 56 +++++
 rtl/mem_stage_load_align.sv | 22 ++
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 memory stage: side-band bundle,
// MEM/WB register layout, FSM states, funct3 and exception codes.
package core_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic        csr_write;
    logic        csr_set;
    logic        csr_clear;
    logic        csr_read;
    logic        csr_info;
    logic [11:0] csr_addr;
    logic        mret;
    logic        mul;
  } mem_side_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instruction;
    logic              rd_write;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
    mem_side_t         side;
    logic              exc_pending;
    logic [3:0]        exc_code;
    logic [XLEN-1:0]   exc_tval;
    logic              exc_interrupt;
  } wb_pipe_t;

  typedef enum logic [1:0] {IDLE, WAIT_RESP, DRAIN} mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  // size is funct3[1:0]: 0 byte, 1 half, 2 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (size)
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// Load data formatter: picks the addressed lane and sign/zero-extends.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    unique case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues loads/stores on the data bus, formats load
// data, flags misaligned accesses and owns the MEM/WB pipeline register.
module mem_stage
  import core_pkg::*;
#(
  parameter bit SUPPORT_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              mem_pipe_valid,
  output logic              mem_pipe_ready,
  output logic              mem_pipe_flush,
  input  logic [XLEN-1:0]   mem_pipe_pc,
  input  logic [XLEN-1:0]   mem_pipe_instruction,
  input  logic              mem_pipe_rd_write,
  input  logic [REG_AW-1:0] mem_pipe_rd_addr,
  input  logic [XLEN-1:0]   mem_pipe_rd_data,
  input  logic              mem_pipe_mem_read,
  input  logic              mem_pipe_mem_write,
  input  logic [2:0]        mem_pipe_mem_funct3,
  input  logic [XLEN-1:0]   mem_pipe_mem_wdata,
  input  mem_side_t         mem_pipe_side,
  input  logic              mem_pipe_exc_pending,
  input  logic [3:0]        mem_pipe_exc_code,
  input  logic [XLEN-1:0]   mem_pipe_exc_tval,
  input  logic              mem_pipe_exc_interrupt,
  output logic              wb_pipe_valid,
  input  logic              wb_pipe_ready,
  input  logic              wb_pipe_flush,
  output logic [XLEN-1:0]   wb_pipe_pc,
  output logic [XLEN-1:0]   wb_pipe_instruction,
  output logic              wb_pipe_rd_write,
  output logic [REG_AW-1:0] wb_pipe_rd_addr,
  output logic [XLEN-1:0]   wb_pipe_rd_data,
  output mem_side_t         wb_pipe_side,
  output logic              wb_pipe_exc_pending,
  output logic [3:0]        wb_pipe_exc_code,
  output logic [XLEN-1:0]   wb_pipe_exc_tval,
  output logic              wb_pipe_exc_interrupt,
  output logic              dbus_req,
  output logic              dbus_write,
  input  logic              dbus_ready,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_rvalid,
  input  logic [XLEN-1:0]   dbus_rdata
);
  mem_state_e      state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;
  wb_pipe_t        wb_q, wb_d;
  logic            wb_valid_q, wb_valid_d;

  logic [2:0]      f3;
  logic [XLEN-1:0] addr;
  logic            access, mis, is_mem, wb_free, stage_done, accept;
  logic [XLEN-1:0] load_data;

  assign f3      = mem_pipe_mem_funct3;
  assign access  = mem_pipe_mem_read | mem_pipe_mem_write;
  assign mis     = SUPPORT_TRAP && access && misaligned(f3[1:0], mem_pipe_rd_data[1:0]);
  assign is_mem  = mem_pipe_valid & access & ~mem_pipe_exc_pending & ~mis;
  assign wb_free = ~wb_valid_q | wb_pipe_ready;
  assign accept  = mem_pipe_valid & mem_pipe_ready & ~wb_pipe_flush;

  assign mem_pipe_flush = wb_pipe_flush;
  assign mem_pipe_ready = stage_done & wb_free;

  // Without trap support a misaligned access is silently rounded down.
  always_comb begin
    addr = mem_pipe_rd_data;
    if (!SUPPORT_TRAP) begin
      case (f3[1:0])
        2'b01:   addr[0]   = 1'b0;
        2'b10:   addr[1:0] = 2'b00;
        default: ;
      endcase
    end
  end

  always_comb begin
    dbus_addr  = addr;
    dbus_write = mem_pipe_mem_write & ~mem_pipe_mem_read;
    case (f3[1:0])
      2'b00: begin
        dbus_wdata = {4{mem_pipe_mem_wdata[7:0]}};
        dbus_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        dbus_wdata = {2{mem_pipe_mem_wdata[15:0]}};
        dbus_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        dbus_wdata = mem_pipe_mem_wdata;
        dbus_wstrb = 4'b1111;
      end
    endcase
    if (!dbus_write) dbus_wstrb = 4'b0000;
  end

  // Issue also waits for a free MEM/WB slot, so a store never completes on the
  // bus without being accepted and a load response always has somewhere to go.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    dbus_req   = 1'b0;
    stage_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        dbus_req = is_mem & ~wb_pipe_flush & wb_free;
        if (!is_mem)                 stage_done = 1'b1;
        else if (dbus_write)         stage_done = dbus_req & dbus_ready;
        if (dbus_req && dbus_ready && !dbus_write) begin
          state_d = WAIT_RESP;
          lane_d  = addr[1:0];
          f3_d    = f3;
        end
      end
      WAIT_RESP: begin
        stage_done = dbus_rvalid;
        if (dbus_rvalid)        state_d = IDLE;
        else if (wb_pipe_flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (dbus_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata  (dbus_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .result (load_data)
  );

  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    if (wb_pipe_ready) wb_valid_d = 1'b0;
    if (accept) begin
      wb_valid_d           = 1'b1;
      wb_d.pc              = mem_pipe_pc;
      wb_d.instruction     = mem_pipe_instruction;
      wb_d.rd_addr         = mem_pipe_rd_addr;
      wb_d.rd_data         = (state_q == WAIT_RESP) ? load_data : mem_pipe_rd_data;
      wb_d.side            = mem_pipe_side;
      wb_d.exc_pending     = mem_pipe_exc_pending;
      wb_d.exc_code        = mem_pipe_exc_code;
      wb_d.exc_tval        = mem_pipe_exc_tval;
      wb_d.exc_interrupt   = mem_pipe_exc_interrupt;
      if (!mem_pipe_exc_pending && mis) begin
        wb_d.exc_pending   = 1'b1;
        wb_d.exc_code      = mem_pipe_mem_read ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        wb_d.exc_tval      = mem_pipe_rd_data;
        wb_d.exc_interrupt = 1'b0;
      end
      wb_d.rd_write = mem_pipe_rd_write & ~wb_d.exc_pending;
    end
    if (wb_pipe_flush) wb_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      f3_q       <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign wb_pipe_valid         = wb_valid_q;
  assign wb_pipe_pc            = wb_q.pc;
  assign wb_pipe_instruction   = wb_q.instruction;
  assign wb_pipe_rd_write      = wb_q.rd_write;
  assign wb_pipe_rd_addr       = wb_q.rd_addr;
  assign wb_pipe_rd_data       = wb_q.rd_data;
  assign wb_pipe_side          = wb_q.side;
  assign wb_pipe_exc_pending   = wb_q.exc_pending;
  assign wb_pipe_exc_code      = wb_q.exc_code;
  assign wb_pipe_exc_tval      = wb_q.exc_tval;
  assign wb_pipe_exc_interrupt = wb_q.exc_interrupt;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a byte-arithmetic reference model.
module tb_mem_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic              mem_pipe_valid, mem_pipe_ready, mem_pipe_flush;
  logic [31:0]       mem_pipe_pc, mem_pipe_instruction, mem_pipe_rd_data, mem_pipe_mem_wdata;
  logic              mem_pipe_rd_write, mem_pipe_mem_read, mem_pipe_mem_write;
  logic [4:0]        mem_pipe_rd_addr;
  logic [2:0]        mem_pipe_mem_funct3;
  mem_side_t         mem_pipe_side, wb_pipe_side;
  logic              mem_pipe_exc_pending, mem_pipe_exc_interrupt;
  logic [3:0]        mem_pipe_exc_code, wb_pipe_exc_code;
  logic [31:0]       mem_pipe_exc_tval;
  logic              wb_pipe_valid, wb_pipe_ready, wb_pipe_flush;
  logic [31:0]       wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_data, wb_pipe_exc_tval;
  logic              wb_pipe_rd_write, wb_pipe_exc_pending, wb_pipe_exc_interrupt;
  logic [4:0]        wb_pipe_rd_addr;
  logic              dbus_req, dbus_write, dbus_ready, dbus_rvalid;
  logic [31:0]       dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]        dbus_wstrb;

  mem_stage #(.SUPPORT_TRAP(1'b1)) dut (
    .clk(clk), .rst_b(rst_b),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
    .mem_pipe_pc(mem_pipe_pc), .mem_pipe_instruction(mem_pipe_instruction),
    .mem_pipe_rd_write(mem_pipe_rd_write), .mem_pipe_rd_addr(mem_pipe_rd_addr),
    .mem_pipe_rd_data(mem_pipe_rd_data), .mem_pipe_mem_read(mem_pipe_mem_read),
    .mem_pipe_mem_write(mem_pipe_mem_write), .mem_pipe_mem_funct3(mem_pipe_mem_funct3),
    .mem_pipe_mem_wdata(mem_pipe_mem_wdata), .mem_pipe_side(mem_pipe_side),
    .mem_pipe_exc_pending(mem_pipe_exc_pending), .mem_pipe_exc_code(mem_pipe_exc_code),
    .mem_pipe_exc_tval(mem_pipe_exc_tval), .mem_pipe_exc_interrupt(mem_pipe_exc_interrupt),
    .wb_pipe_valid(wb_pipe_valid), .wb_pipe_ready(wb_pipe_ready), .wb_pipe_flush(wb_pipe_flush),
    .wb_pipe_pc(wb_pipe_pc), .wb_pipe_instruction(wb_pipe_instruction),
    .wb_pipe_rd_write(wb_pipe_rd_write), .wb_pipe_rd_addr(wb_pipe_rd_addr),
    .wb_pipe_rd_data(wb_pipe_rd_data), .wb_pipe_side(wb_pipe_side),
    .wb_pipe_exc_pending(wb_pipe_exc_pending), .wb_pipe_exc_code(wb_pipe_exc_code),
    .wb_pipe_exc_tval(wb_pipe_exc_tval), .wb_pipe_exc_interrupt(wb_pipe_exc_interrupt),
    .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_ready(dbus_ready),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, instr, rd_data, wdata, rdata, tval;
    logic [4:0]  rd_addr;
    logic        rd_write, rd, wr, exc, intr;
    logic [2:0]  f3;
    logic [3:0]  code;
    mem_side_t   side;
    int          rdy_dly, rv_dly;
  } txn_t;

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Load value: shift the addressed byte lane down, keep n bytes, then sign-extend arithmetically.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [2:0] f3);
    int n;
    longint v;
    n = nbytes(f3);
    v = longint'(rdata >> (8 * (a % 4)));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    mem_pipe_valid = 0; mem_pipe_pc = 0; mem_pipe_instruction = 0; mem_pipe_rd_write = 0;
    mem_pipe_rd_addr = 0; mem_pipe_rd_data = 0; mem_pipe_mem_read = 0; mem_pipe_mem_write = 0;
    mem_pipe_mem_funct3 = 0; mem_pipe_mem_wdata = 0; mem_pipe_side = '0;
    mem_pipe_exc_pending = 0; mem_pipe_exc_code = 0; mem_pipe_exc_tval = 0;
    mem_pipe_exc_interrupt = 0; dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = 0;
  endtask

  task automatic drive(input txn_t t);
    mem_pipe_valid = 1; mem_pipe_pc = t.pc; mem_pipe_instruction = t.instr;
    mem_pipe_rd_write = t.rd_write; mem_pipe_rd_addr = t.rd_addr; mem_pipe_rd_data = t.rd_data;
    mem_pipe_mem_read = t.rd; mem_pipe_mem_write = t.wr; mem_pipe_mem_funct3 = t.f3;
    mem_pipe_mem_wdata = t.wdata; mem_pipe_side = t.side; mem_pipe_exc_pending = t.exc;
    mem_pipe_exc_code = t.code; mem_pipe_exc_tval = t.tval; mem_pipe_exc_interrupt = t.intr;
  endtask

  function automatic txn_t nonmem(input logic [31:0] res);
    txn_t t;
    t = '{pc: 32'h100, instr: 32'h00000033, rd_data: res, wdata: 0, rdata: 0, tval: 0,
          rd_addr: 5'd7, rd_write: 1, rd: 0, wr: 0, exc: 0, intr: 0, f3: 0, code: 0,
          side: '0, rdy_dly: 0, rv_dly: 0};
    return t;
  endfunction

  // One instruction end to end; leaves the bench at a negedge+1 with its writeback visible.
  task automatic do_op(input txn_t t);
    int n;
    logic mis, mem, exc_e;
    logic [3:0] code_e, ws_e;
    logic [31:0] tval_e, rdd_e, wd_e;
    n      = nbytes(t.f3);
    mis    = (t.rd | t.wr) && (t.rd_data % n != 0);
    exc_e  = t.exc | mis;
    mem    = (t.rd | t.wr) & ~exc_e;
    code_e = t.exc ? t.code : (t.rd ? 4'd4 : 4'd6);
    tval_e = t.exc ? t.tval : t.rd_data;
    rdd_e  = (mem && t.rd) ? model_load(t.rdata, t.rd_data, t.f3) : t.rd_data;
    wd_e   = (n == 1) ? (t.wdata & 32'hFF) * 32'h01010101 :
             (n == 2) ? (t.wdata & 32'hFFFF) * 32'h00010001 : t.wdata;
    ws_e   = 4'(((1 << n) - 1) << (t.rd_data % 4));

    @(negedge clk);
    drive(t);
    dbus_ready = (t.rdy_dly == 0);
    dbus_rvalid = 0;
    #1;
    if (!mem) begin
      chk("nm_ready", 32'(mem_pipe_ready), 1);
      chk("nm_req", 32'(dbus_req), 0);
    end else begin
      for (int k = 0; k <= t.rdy_dly; k++) begin
        if (k > 0) begin
          @(negedge clk);
          dbus_ready = (k == t.rdy_dly);
          #1;
        end
        chk("req", 32'(dbus_req), 1);
        chk("addr", dbus_addr, t.rd_data);
        chk("we", 32'(dbus_write), 32'(t.wr));
        chk("wstrb", 32'(dbus_wstrb), t.wr ? 32'(ws_e) : 0);
        if (t.wr) chk("wdata", dbus_wdata, wd_e);
        chk("rdy_req", 32'(mem_pipe_ready), 32'(t.wr && dbus_ready));
      end
      if (t.rd) begin
        @(negedge clk);
        dbus_ready = 0;
        for (int k = 0; k < t.rv_dly; k++) begin
          #1;
          chk("rdy_wait", 32'(mem_pipe_ready), 0);
          chk("req_wait", 32'(dbus_req), 0);
          @(negedge clk);
        end
        dbus_rvalid = 1;
        dbus_rdata = t.rdata;
        #1;
        chk("rdy_rv", 32'(mem_pipe_ready), 1);
      end
    end
    @(negedge clk);
    mem_pipe_valid = 0; dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = $urandom;
    #1;
    chk("wb_valid", 32'(wb_pipe_valid), 1);
    chk("wb_pc", wb_pipe_pc, t.pc);
    chk("wb_instr", wb_pipe_instruction, t.instr);
    chk("wb_rd_data", wb_pipe_rd_data, rdd_e);
    chk("wb_rd_write", 32'(wb_pipe_rd_write), 32'(t.rd_write & ~exc_e));
    chk("wb_rd_addr", 32'(wb_pipe_rd_addr), 32'(t.rd_addr));
    chk("wb_side", 32'(wb_pipe_side), 32'(t.side));
    chk("wb_exc", 32'(wb_pipe_exc_pending), 32'(exc_e));
    if (exc_e) begin
      chk("wb_code", 32'(wb_pipe_exc_code), 32'(code_e));
      chk("wb_tval", wb_pipe_exc_tval, tval_e);
      chk("wb_intr", 32'(wb_pipe_exc_interrupt), 32'(t.exc & t.intr));
    end
  endtask

  task automatic rand_txn(output txn_t t);
    logic [31:0] r;
    int kind, n;
    r = $urandom;
    kind = $urandom_range(0, 2);
    t = nonmem($urandom);
    t.pc = $urandom; t.instr = $urandom; t.rd_addr = r[4:0]; t.rd_write = r[5];
    t.side = r[$bits(mem_side_t)-1:0];
    t.rdy_dly = $urandom_range(0, 3); t.rv_dly = $urandom_range(0, 3);
    t.rdata = $urandom; t.wdata = $urandom;
    if (kind == 1) begin
      t.rd = 1;
      case ($urandom_range(0, 4))
        0: t.f3 = F3_LB; 1: t.f3 = F3_LH; 2: t.f3 = F3_LW; 3: t.f3 = F3_LBU; default: t.f3 = F3_LHU;
      endcase
    end else if (kind == 2) begin
      t.wr = 1;
      t.f3 = 3'($urandom_range(0, 2));
    end
    n = nbytes(t.f3);
    if ((t.rd | t.wr) && $urandom_range(0, 3) != 0) t.rd_data = t.rd_data - (t.rd_data % n);
    if ($urandom_range(0, 9) == 0) begin
      t.exc = 1; t.code = 4'($urandom_range(0, 15)); t.tval = $urandom; t.intr = r[31];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    idle_inputs();
    wb_pipe_ready = 1; wb_pipe_flush = 0;
    #1;
    chk("rst_wb_valid", 32'(wb_pipe_valid), 0);
    chk("rst_req", 32'(dbus_req), 0);
    chk("rst_rd_data", wb_pipe_rd_data, 0);
    chk("rst_exc", 32'(wb_pipe_exc_pending), 0);
    chk("rst_pc", wb_pipe_pc, 0);
    repeat (2) @(negedge clk);
    rst_b = 1;

    // Directed scenarios
    do_op(nonmem(32'h1234));
    t = nonmem(32'h1003); t.wr = 1; t.f3 = F3_SB; t.wdata = 32'h000000AB; do_op(t);
    t = nonmem(32'h2001); t.rd = 1; t.f3 = F3_LB; t.rdata = 32'h000080FF; do_op(t);
    t.f3 = F3_LBU; do_op(t);
    t = nonmem(32'h2002); t.rd = 1; t.f3 = F3_LW; do_op(t);
    t = nonmem(32'h11); t.wr = 1; t.f3 = F3_SH; do_op(t);
    t = nonmem(32'h4000); t.wr = 1; t.f3 = F3_SW; t.wdata = 32'hDEADBEEF; t.rdy_dly = 4; do_op(t);
    t = nonmem(32'h5006); t.rd = 1; t.f3 = F3_LH; t.rdata = 32'h9ABC1234; t.rv_dly = 2; do_op(t);

    // WB back-pressure holds the MEM/WB register
    wb_pipe_ready = 0;
    @(negedge clk);
    drive(nonmem(32'hBEEF));
    #1;
    chk("bp_ready", 32'(mem_pipe_ready), 0);
    chk("bp_hold", wb_pipe_rd_data, 32'h5006 + 32'h0 + model_load(32'h9ABC1234, 32'h5006, F3_LH) - 32'h5006);
    wb_pipe_ready = 1;
    #1;
    chk("bp_release", 32'(mem_pipe_ready), 1);
    @(negedge clk);
    mem_pipe_valid = 0;
    #1;
    chk("bp_wb", wb_pipe_rd_data, 32'hBEEF);

    // Flush while waiting for a load response: drain it, nothing written back
    @(negedge clk);
    t = nonmem(32'h3000); t.rd = 1; t.f3 = F3_LW; drive(t);
    dbus_ready = 1;
    #1;
    chk("fl_req", 32'(dbus_req), 1);
    @(negedge clk);
    dbus_ready = 0; wb_pipe_flush = 1;
    #1;
    chk("fl_ready", 32'(mem_pipe_ready), 0);
    @(negedge clk);
    wb_pipe_flush = 0;
    drive(nonmem(32'h55));
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin dbus_rvalid = 1; dbus_rdata = 32'hFFFF0000; end
      #1;
      chk("dr_ready", 32'(mem_pipe_ready), 0);
      chk("dr_req", 32'(dbus_req), 0);
      chk("dr_wb_valid", 32'(wb_pipe_valid), 0);
      @(negedge clk);
    end
    dbus_rvalid = 0;
    #1;
    chk("dr_idle", 32'(mem_pipe_ready), 1);
    @(negedge clk);
    mem_pipe_valid = 0;
    #1;
    chk("dr_next_valid", 32'(wb_pipe_valid), 1);
    chk("dr_next_data", wb_pipe_rd_data, 32'h55);

    // Flush coinciding with the response goes straight back to IDLE
    @(negedge clk);
    t = nonmem(32'h3004); t.rd = 1; t.f3 = F3_LW; drive(t);
    dbus_ready = 1;
    @(negedge clk);
    dbus_ready = 0; dbus_rvalid = 1; wb_pipe_flush = 1;
    @(negedge clk);
    dbus_rvalid = 0; wb_pipe_flush = 0;
    drive(nonmem(32'h77));
    #1;
    chk("sim_ready", 32'(mem_pipe_ready), 1);
    chk("sim_wb_valid", 32'(wb_pipe_valid), 0);
    @(negedge clk);
    mem_pipe_valid = 0;
    #1;
    chk("sim_next", wb_pipe_rd_data, 32'h77);

    // Reset while a load is outstanding
    @(negedge clk);
    t = nonmem(32'h3008); t.rd = 1; t.f3 = F3_LW; drive(t);
    dbus_ready = 1;
    @(negedge clk);
    dbus_ready = 0; mem_pipe_valid = 0; rst_b = 0;
    #1;
    chk("mrst_wb_valid", 32'(wb_pipe_valid), 0);
    @(negedge clk);
    rst_b = 1;
    drive(nonmem(32'h99));
    #1;
    chk("mrst_ready", 32'(mem_pipe_ready), 1);
    @(negedge clk);
    mem_pipe_valid = 0;

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      rand_txn(t);
      do_op(t);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
